pool_window_gen: RTL and testbench

Streaming window generator placed directly upstream of the 2x2 average-pooling stage. Accepts an N x N feature map as a raster stream of signed 16-bit pixels, one per cycle. Buffers one row and emits each non-overlapping 2x2 window (stride 2) as four registered pixels with a valid/ready handshake. The pooling stage consumes one window per transfer, so the map is reduced with no frame-sized storage.

---
 rtl/pool_pkg.sv | 23 ++
 rtl/pool_line_buf.sv | 31 +++
 rtl/pool_window_gen.sv | 173 +++++++++++++++++
 tb/tb_pool_window_gen.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pool_pkg.sv
// Shared types for the 2x2 pooling window generator.
// POOL_WIN_ODD_PAD_EN adds the ROW_LAST state used for zero-padded odd-size maps.
package pool_pkg;

  localparam int unsigned PixW = 16;

  typedef logic signed [PixW-1:0] pix_t;

  typedef struct packed {
    pix_t w00;
    pix_t w01;
    pix_t w10;
    pix_t w11;
    logic last;
  } win_t;

`ifdef POOL_WIN_ODD_PAD_EN
  typedef enum logic [1:0] {ROW_TOP, ROW_BOT, ROW_LAST} state_e;
`else
  typedef enum logic [1:0] {ROW_TOP, ROW_BOT} state_e;
`endif

endpackage

// File: rtl/pool_line_buf.sv
// One-row line buffer: single write port, combinational reads at columns c-1 and c.
// Not reset; every entry is rewritten by the top row before it is read.
module pool_line_buf
  import pool_pkg::*;
#(
  parameter int unsigned N  = 5,
  parameter int unsigned AW = $clog2(N)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  pix_t          wdata,
  input  logic [AW-1:0] raddr,
  output pix_t          rdata_lo,
  output pix_t          rdata_hi
);

  pix_t          mem [N];
  logic [AW-1:0] lo_addr;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign lo_addr  = (raddr == '0) ? '0 : raddr - 1'b1;
  assign rdata_lo = mem[lo_addr];
  assign rdata_hi = mem[raddr];

endmodule

// File: rtl/pool_window_gen.sv
// Streaming 2x2 / stride-2 window generator feeding the average-pooling stage.
// Define POOL_WIN_ODD_PAD_EN to emit zero-padded edge windows for odd N.
module pool_window_gen
  import pool_pkg::*;
#(
  parameter int unsigned N  = 5,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_valid,
  input  logic [DW-1:0] pix_in,
  output logic          pix_ready,
  output logic          win_valid,
  input  logic          win_ready,
  output logic [DW-1:0] win_00,
  output logic [DW-1:0] win_01,
  output logic [DW-1:0] win_10,
  output logic [DW-1:0] win_11,
  output logic          win_last,
  output logic          map_done
);

  localparam int unsigned CW = $clog2(N);
  localparam logic [CW-1:0] Max = CW'(N - 1);
  localparam bit OddN = (N % 2) == 1;
`ifdef POOL_WIN_ODD_PAD_EN
  localparam bit PadEn = 1'b1;
`else
  localparam bit PadEn = 1'b0;
`endif
  // Coordinate of the pixel that completes the final window of a map.
  localparam logic [CW-1:0] LastIdx = (PadEn || !OddN) ? CW'(N - 1) : CW'(N - 2);

  state_e        state_q, state_d;
  logic [CW-1:0] col_q, row_q;
  pix_t          prev_q;
  win_t          win_q, win_d;
  logic          win_valid_q;
  logic          map_done_q;
  logic          accept;
  logic          load;
  logic          lb_we;
  pix_t          lb_lo, lb_hi;
  pix_t          pix;

  assign pix       = pix_t'(pix_in);
  assign pix_ready = !win_valid_q || win_ready;
  assign accept    = pix_valid && pix_ready;
  assign lb_we     = accept && (state_q == ROW_TOP);

  pool_line_buf #(
    .N  (N),
    .AW (CW)
  ) u_line_buf (
    .clk      (clk),
    .we       (lb_we),
    .waddr    (col_q),
    .wdata    (pix),
    .raddr    (col_q),
    .rdata_lo (lb_lo),
    .rdata_hi (lb_hi)
  );

  always_comb begin
    state_d = state_q;
    if (accept && (col_q == Max)) begin
      if (row_q == Max) begin
        state_d = ROW_TOP;
      end
`ifdef POOL_WIN_ODD_PAD_EN
      else if (OddN && (row_q == CW'(N - 2))) begin
        state_d = ROW_LAST;
      end
`endif
      else if (state_q == ROW_TOP) begin
        state_d = ROW_BOT;
      end else begin
        state_d = ROW_TOP;
      end
    end
  end

  always_comb begin
    load       = 1'b0;
    win_d      = win_q;
    win_d.last = (row_q == LastIdx) && (col_q == LastIdx);
    case (state_q)
      ROW_BOT: begin
        if (col_q[0]) begin
          load      = accept;
          win_d.w00 = lb_lo;
          win_d.w01 = lb_hi;
          win_d.w10 = prev_q;
          win_d.w11 = pix;
        end
`ifdef POOL_WIN_ODD_PAD_EN
        else if (OddN && (col_q == Max)) begin
          load      = accept;
          win_d.w00 = lb_hi;
          win_d.w01 = '0;
          win_d.w10 = pix;
          win_d.w11 = '0;
        end
`endif
      end
`ifdef POOL_WIN_ODD_PAD_EN
      ROW_LAST: begin
        if (col_q[0]) begin
          load      = accept;
          win_d.w00 = prev_q;
          win_d.w01 = pix;
          win_d.w10 = '0;
          win_d.w11 = '0;
        end else if (col_q == Max) begin
          load      = accept;
          win_d.w00 = pix;
          win_d.w01 = '0;
          win_d.w10 = '0;
          win_d.w11 = '0;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ROW_TOP;
      col_q   <= '0;
      row_q   <= '0;
      prev_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        prev_q <= pix;
        if (col_q == Max) begin
          col_q <= '0;
          row_q <= (row_q == Max) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

  // A load in the same cycle as a drain overwrites and keeps win_valid high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q       <= '0;
      win_valid_q <= 1'b0;
      map_done_q  <= 1'b0;
    end else begin
      map_done_q <= accept && (row_q == Max) && (col_q == Max);
      if (load) begin
        win_q       <= win_d;
        win_valid_q <= 1'b1;
      end else if (win_valid_q && win_ready) begin
        win_valid_q <= 1'b0;
      end
    end
  end

  assign win_valid = win_valid_q;
  assign win_00    = win_q.w00;
  assign win_01    = win_q.w01;
  assign win_10    = win_q.w10;
  assign win_11    = win_q.w11;
  assign win_last  = win_q.last;
  assign map_done  = map_done_q;

endmodule

// File: tb/tb_pool_window_gen.sv
// Self-checking bench for pool_window_gen: an N=4 and an N=5 instance, each checked
// against a reference window list computed from the raw pixel map.
module tb_pool_window_gen;

`ifdef POOL_WIN_ODD_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        win_ready;
  logic [15:0] pix_in;
  logic        pv  [2];
  logic        pr  [2];
  logic        wv  [2];
  logic        wl  [2];
  logic        md  [2];
  logic [15:0] w00 [2];
  logic [15:0] w01 [2];
  logic [15:0] w10 [2];
  logic [15:0] w11 [2];

  logic [64:0] q0 [$];
  logic [64:0] q1 [$];
  int          ndone [2];
  int          n_cmp = 0;
  int          n_fail = 0;
  bit          held [2];
  logic [64:0] heldv [2];
  logic [64:0] cur_m, exp_m;
  int          sz;

  always #5 clk = ~clk;

  pool_window_gen #(.N(4), .DW(16)) u_dut4 (
    .clk(clk), .rst(rst), .pix_valid(pv[0]), .pix_in(pix_in), .pix_ready(pr[0]),
    .win_valid(wv[0]), .win_ready(win_ready), .win_00(w00[0]), .win_01(w01[0]),
    .win_10(w10[0]), .win_11(w11[0]), .win_last(wl[0]), .map_done(md[0])
  );

  pool_window_gen #(.N(5), .DW(16)) u_dut5 (
    .clk(clk), .rst(rst), .pix_valid(pv[1]), .pix_in(pix_in), .pix_ready(pr[1]),
    .win_valid(wv[1]), .win_ready(win_ready), .win_00(w00[1]), .win_01(w01[1]),
    .win_10(w10[1]), .win_11(w11[1]), .win_last(wl[1]), .map_done(md[1])
  );

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Does accepting raster pixel k of an n x n map complete a window?
  function automatic bit completes(input int n, input int k);
    int r = k / n;
    int c = k % n;
    bit f = (r % 2 == 1) && (c % 2 == 1);
    if (PAD && (n % 2 == 1))
      f = f || ((r % 2 == 1) && (c == n - 1)) || ((r == n - 1) && ((c % 2 == 1) || (c == n - 1)));
    return f;
  endfunction

  // Scoreboard: every transfer must match the next reference window; stalled windows must hold.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      held[0] = 1'b0;
      held[1] = 1'b0;
    end else begin
      for (int s = 0; s < 2; s++) begin
        cur_m = {w00[s], w01[s], w10[s], w11[s], wl[s]};
        if (held[s]) begin
          chk("hold_valid", wv[s], 1'b1);
          chk("hold_window", cur_m, heldv[s]);
        end
        held[s] = 1'b0;
        if (wv[s] && win_ready) begin
          sz = (s == 0) ? q0.size() : q1.size();
          chk("window_expected", sz != 0, 1'b1);
          if (sz != 0) begin
            if (s == 0) exp_m = q0.pop_front();
            else exp_m = q1.pop_front();
            chk((s == 0) ? "window_n4" : "window_n5", cur_m, exp_m);
          end
        end else if (wv[s]) begin
          held[s]  = 1'b1;
          heldv[s] = cur_m;
        end
        if (md[s]) ndone[s]++;
      end
    end
  end

  // kind: 0 sequential 0.., 1 random, 2 random with extreme values in the first window.
  task automatic run_map(input int s, input int n, input int npix, input int kind,
                         input int vpct, input int rpct, input int stall, input bit timing);
    logic [15:0] px[$];
    logic [64:0] wins[$];
    logic [64:0] tmp;
    logic [15:0] a, b, cc, d;
    bit          hr, hd, stalled, acc;
    int          k, last, cyc, stall_left, done0;
    for (int i = 0; i < n * n; i++) begin
      if (kind == 0) px.push_back(16'(i));
      else px.push_back(16'($urandom));
    end
    if (kind == 2) begin
      px[0] = 16'h8000; px[1] = 16'h7fff; px[n] = 16'h7fff; px[n + 1] = 16'h8000;
    end
    for (int r = 0; r < n; r += 2) begin
      for (int c = 0; c < n; c += 2) begin
        hr = (c + 1 < n);
        hd = (r + 1 < n);
        if ((hr && hd) || PAD) begin
          a  = px[r * n + c];
          b  = hr ? px[r * n + c + 1] : 16'h0;
          cc = hd ? px[(r + 1) * n + c] : 16'h0;
          d  = (hr && hd) ? px[(r + 1) * n + c + 1] : 16'h0;
          wins.push_back({a, b, cc, d, 1'b0});
        end
      end
    end
    tmp = wins.pop_back();
    tmp[0] = 1'b1;
    wins.push_back(tmp);
    foreach (wins[i]) begin
      if (s == 0) q0.push_back(wins[i]);
      else q1.push_back(wins[i]);
    end
    done0 = ndone[s];
    k = 0; last = -1; cyc = 0; stall_left = 0; stalled = 1'b0;
    while (k < npix && cyc < 2000) begin
      pv[s]  = ($urandom_range(99) < vpct);
      pix_in = px[k];
      if (stall_left > 0) begin
        win_ready = 1'b0;
        stall_left--;
      end else begin
        win_ready = ($urandom_range(99) < rpct);
      end
      @(negedge clk);
      if (stall > 0 && !stalled && wv[s]) begin
        stalled    = 1'b1;
        win_ready  = 1'b0;
        stall_left = stall - 1;
      end
      #1;
      chk("pix_ready_rule", pr[s], !wv[s] || win_ready);
      if (timing) begin
        chk("win_valid_latency", wv[s], (last >= 0) && completes(n, last));
        chk("map_done_timing", md[s], last == n * n - 1);
      end
      acc = pv[s] && pr[s];
      @(posedge clk);
      #1;
      last = acc ? k : -1;
      if (acc) k++;
      cyc++;
    end
    pv[s] = 1'b0;
    chk("stream_progress", k, npix);
    if (timing) begin
      @(negedge clk);
      #1;
      chk("win_valid_latency", wv[s], (last >= 0) && completes(n, last));
      chk("map_done_timing", md[s], last == n * n - 1);
      @(posedge clk);
      #1;
    end
    if (npix == n * n) begin
      win_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("windows_left", (s == 0) ? q0.size() : q1.size(), 0);
      chk("map_done_count", ndone[s] - done0, 1);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; win_ready = 1'b1; pix_in = '0;
    pv[0] = 1'b0; pv[1] = 1'b0;
    ndone[0] = 0; ndone[1] = 0;
    #12;
    for (int s = 0; s < 2; s++) begin
      chk("reset_pix_ready", pr[s], 1'b1);
      chk("reset_outputs", {wv[s], md[s], w00[s], w01[s], w10[s], w11[s], wl[s]}, '0);
    end
    #5 rst = 1'b0;
    @(posedge clk);
    #1;

    run_map(0, 4, 16, 0, 100, 100, 0, 1'b1);  // windows after pixels 5/7/13/15
    run_map(0, 4, 16, 0, 100, 100, 5, 1'b0);  // 5-cycle stall on the first window
    run_map(1, 5, 25, 0, 100, 100, 0, 1'b1);  // odd N
    run_map(1, 5, 25, 2, 100, 100, 0, 1'b1);  // -32768 / 32767 pass-through
    run_map(0, 4, 16, 2, 100, 100, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      run_map(0, 4, 16, 1, 80, 60, 0, 1'b0);
      run_map(1, 5, 25, 1, 70, 50, 0, 1'b0);
    end
    run_map(0, 4, 16, 1, 100, 100, 0, 1'b1);
    run_map(0, 4, 16, 1, 100, 100, 0, 1'b1);

    // Reset mid-map with a window pending: it must vanish without a clock edge.
    run_map(0, 4, 6, 0, 100, 100, 0, 1'b0);
    win_ready = 1'b0;
    #2;
    chk("pending_before_reset", wv[0], 1'b1);
    rst = 1'b1;
    #1;
    chk("async_reset_valid", wv[0], 1'b0);
    chk("async_reset_window", {w00[0], w01[0], w10[0], w11[0], wl[0]}, '0);
    q0.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    win_ready = 1'b1;
    @(posedge clk);
    #1;
    run_map(0, 4, 16, 0, 100, 100, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
